instr_encoder: RTL and testbench

Sequential encoder that is the inverse of the core's control decoder. It accepts symbolic instructions (opcode enum plus register and immediate fields) over a valid/ready stream and packs each one into the 9-bit machine word. Encoded words are written to instruction memory through an auto-incrementing address counter. It is used as the on-chip program loader and by the bench to build instruction images. It also handles the FILL and ORG pseudo-ops, range-checks every field, and counts errors.

---
 rtl/instr_encoder_if.sv | 15 +
 rtl/instr_encoder.sv | 194 +++++++++++++++++++
 tb/tb_instr_encoder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Symbolic instruction stream into the encoder: valid/ready handshake plus
// opcode, register and immediate fields.
interface instr_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_op;
  logic [2:0] in_rd;
  logic [2:0] in_rs;
  logic [7:0] in_imm;

  modport master (output in_valid, output in_op, output in_rd, output in_rs, output in_imm,
                  input  in_ready);
  modport slave  (input  in_valid, input  in_op, input  in_rd, input  in_rs, input  in_imm,
                  output in_ready);
endinterface

// File: rtl/instr_encoder.sv
// Program loader: packs symbolic instructions into 9-bit machine words and writes
// them to instruction memory through an auto-incrementing, non-wrapping address.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  instr_encoder_if.slave    bus,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [8:0]        wr_data,
  output logic              mem_full,
  output logic              err_pulse,
  output logic [1:0]        err_code,
  output logic [7:0]        err_count
);
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FILL = 1'b1} state_t;

  localparam logic [4:0]        OP_FILL  = 5'd19;
  localparam logic [4:0]        OP_ORG   = 5'd20;
  localparam logic [4:0]        OP_RSVD  = 5'd21;
  localparam logic [8:0]        NOP_WORD = 9'h150;
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  function automatic logic [8:0] encode_word(input logic [4:0] op, input logic [2:0] rd,
                                             input logic [2:0] rs, input logic [7:0] imm);
    logic [8:0] w;
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3,
      5'd4, 5'd5, 5'd6, 5'd7:    w = {2'b00, op[2:0], rd[1:0], rs[1:0]};
      5'd8, 5'd9, 5'd10, 5'd11:  w = {2'b01, op[1:0], imm[4:0]};
      5'd12:                     w = {2'b10, 3'b000, imm[3:0]};
      5'd13:                     w = {2'b10, 3'b010, rd[1:0], rs[1:0]};
      5'd14:                     w = {2'b10, 3'b011, rd[1:0], rs[1:0]};
      5'd15:                     w = {2'b10, 3'b100, rd[1:0], rs[1:0]};
      5'd17:                     w = {2'b11, 1'b0, rd, rs};
      5'd18:                     w = {2'b11, 1'b1, imm[5:0]};
      default:                   w = NOP_WORD;
    endcase
    return w;
  endfunction

  // Branch offsets are signed 5-bit, so the upper nibble must be pure sign extension.
  function automatic logic range_ok(input logic [4:0] op, input logic [2:0] rd,
                                    input logic [2:0] rs, input logic [7:0] imm);
    logic ok;
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
      5'd13, 5'd14, 5'd15:       ok = ~rd[2] & ~rs[2];
      5'd8, 5'd9, 5'd10, 5'd11:  ok = (imm[7:4] == 4'h0) || (imm[7:4] == 4'hF);
      5'd12:                     ok = (imm[7:4] == 4'h0);
      5'd18:                     ok = (imm[7:6] == 2'b00);
      default:                   ok = 1'b1;
    endcase
    return ok;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [7:0]        fill_cnt_r, fill_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic              mem_full_r, full_nxt_s;
  logic              wr_en_r, wr_en_nxt_s;
  logic [ADDR_W-1:0] wr_addr_r, wr_addr_nxt_s;
  logic [8:0]        wr_data_r, wr_data_nxt_s;
  logic              err_pulse_r, err_nxt_s;
  logic [1:0]        err_code_r, code_nxt_s;
  logic [7:0]        err_count_r, count_nxt_s;
  logic              accept_s, do_write_s;
  logic [8:0]        word_s;

  assign bus.in_ready = (state_r == ST_IDLE);
  assign accept_s     = bus.in_valid & bus.in_ready;

  // Next-state, memory write and error decision for the current cycle.
  always_comb begin
    state_nxt_s   = state_r;
    fill_nxt_s    = fill_cnt_r;
    addr_nxt_s    = addr_r;
    full_nxt_s    = mem_full_r;
    wr_en_nxt_s   = 1'b0;
    wr_addr_nxt_s = wr_addr_r;
    wr_data_nxt_s = wr_data_r;
    err_nxt_s     = 1'b0;
    code_nxt_s    = err_code_r;
    count_nxt_s   = err_count_r;
    do_write_s    = 1'b0;
    word_s        = NOP_WORD;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (bus.in_op >= OP_RSVD) begin
            err_nxt_s  = 1'b1;
            code_nxt_s = 2'd1;
          end else if (!range_ok(bus.in_op, bus.in_rd, bus.in_rs, bus.in_imm)) begin
            err_nxt_s  = 1'b1;
            code_nxt_s = 2'd0;
          end else if (bus.in_op == OP_FILL) begin
            if (bus.in_imm != 8'd0) begin
              state_nxt_s = ST_FILL;
              fill_nxt_s  = bus.in_imm;
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end else if (bus.in_op == OP_ORG) begin
            addr_nxt_s = ADDR_W'(bus.in_imm);
            full_nxt_s = 1'b0;
          end else if (mem_full_r) begin
            err_nxt_s  = 1'b1;
            code_nxt_s = 2'd2;
          end else begin
            do_write_s = 1'b1;
            word_s     = encode_word(bus.in_op, bus.in_rd, bus.in_rs, bus.in_imm);
          end
        end else begin
          do_write_s = 1'b0;
        end
      end
      ST_FILL: begin
        // Running out of memory abandons the rest of the fill after one overflow error.
        if (mem_full_r) begin
          err_nxt_s   = 1'b1;
          code_nxt_s  = 2'd2;
          state_nxt_s = ST_IDLE;
          fill_nxt_s  = 8'd0;
        end else begin
          do_write_s = 1'b1;
          fill_nxt_s = fill_cnt_r - 8'd1;
          if (fill_cnt_r == 8'd1) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_FILL;
          end
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    if (do_write_s) begin
      wr_en_nxt_s   = 1'b1;
      wr_addr_nxt_s = addr_r;
      wr_data_nxt_s = word_s;
      if (addr_r == ADDR_MAX) begin
        full_nxt_s = 1'b1;
      end else begin
        addr_nxt_s = addr_r + ADDR_W'(1);
      end
    end else begin
      wr_en_nxt_s = 1'b0;
    end

    if (err_nxt_s && (err_count_r != 8'hFF)) begin
      count_nxt_s = err_count_r + 8'd1;
    end else begin
      count_nxt_s = err_count_r;
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= ST_IDLE;
      fill_cnt_r  <= 8'd0;
      addr_r      <= '0;
      mem_full_r  <= 1'b0;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= 9'd0;
      err_pulse_r <= 1'b0;
      err_code_r  <= 2'd0;
      err_count_r <= 8'd0;
    end else begin
      state_r     <= state_nxt_s;
      fill_cnt_r  <= fill_nxt_s;
      addr_r      <= addr_nxt_s;
      mem_full_r  <= full_nxt_s;
      wr_en_r     <= wr_en_nxt_s;
      wr_addr_r   <= wr_addr_nxt_s;
      wr_data_r   <= wr_data_nxt_s;
      err_pulse_r <= err_nxt_s;
      err_code_r  <= code_nxt_s;
      err_count_r <= count_nxt_s;
    end
  end

  assign wr_en     = wr_en_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign mem_full  = mem_full_r;
  assign err_pulse = err_pulse_r;
  assign err_code  = err_code_r;
  assign err_count = err_count_r;
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios then random traffic, all checked
// cycle by cycle against an arithmetic reference model of the loader.
module tb_instr_encoder;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          Clk;
  logic          Reset_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [8:0]    wr_data;
  logic          mem_full;
  logic          err_pulse;
  logic [1:0]    err_code;
  logic [7:0]    err_count;

  int n_checks;
  int n_errors;

  // Reference model state
  int m_addr, m_full, m_fill, m_cnt;

  instr_encoder_if bus ();

  instr_encoder #(.ADDR_W(AW)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .bus       (bus),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .mem_full  (mem_full),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .err_count (err_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int enc_m(int op, int rd, int rs, int imm);
    if (op <= 7)  return op * 16 + rd * 4 + rs;
    if (op <= 11) return 128 + (op - 8) * 32 + (imm % 32);
    if (op == 12) return 256 + imm;
    if (op <= 15) return 256 + (op - 11) * 16 + rd * 4 + rs;
    if (op == 16) return 336;
    if (op == 17) return 384 + rd * 8 + rs;
    return 448 + imm;
  endfunction

  function automatic bit legal_m(int op, int rd, int rs, int imm);
    if (op <= 7 || (op >= 13 && op <= 15)) return (rd < 4) && (rs < 4);
    if (op >= 8 && op <= 11) return (imm <= 15) || (imm >= 240);
    if (op == 12) return imm <= 15;
    if (op == 18) return imm <= 63;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_addr = 0; m_full = 0; m_fill = 0; m_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string where);
    check_val({where, ".in_ready"},  bus.in_ready, 1);
    check_val({where, ".wr_en"},     wr_en, 0);
    check_val({where, ".wr_addr"},   wr_addr, 0);
    check_val({where, ".wr_data"},   wr_data, 0);
    check_val({where, ".mem_full"},  mem_full, 0);
    check_val({where, ".err_pulse"}, err_pulse, 0);
    check_val({where, ".err_code"},  err_code, 0);
    check_val({where, ".err_count"}, err_count, 0);
  endtask

  // One clock: predict from current inputs, clock, compare every output.
  task automatic step();
    int op, rd, rs, imm;
    int e_wr, e_addr, e_data, e_err, e_code;
    op = bus.in_op; rd = bus.in_rd; rs = bus.in_rs; imm = bus.in_imm;
    e_wr = 0; e_addr = 0; e_data = 0; e_err = 0; e_code = 0;
    check_val("in_ready", bus.in_ready, (m_fill == 0));
    if (m_fill > 0) begin
      if (m_full != 0) begin
        e_err = 1; e_code = 2; m_fill = 0;
      end else begin
        e_wr = 1; e_data = 336; m_fill--;
      end
    end else if (bus.in_valid) begin
      if (op >= 21) begin
        e_err = 1; e_code = 1;
      end else if (!legal_m(op, rd, rs, imm)) begin
        e_err = 1; e_code = 0;
      end else if (op == 19) begin
        m_fill = imm;
      end else if (op == 20) begin
        m_addr = imm % DEPTH; m_full = 0;
      end else if (m_full != 0) begin
        e_err = 1; e_code = 2;
      end else begin
        e_wr = 1; e_data = enc_m(op, rd, rs, imm);
      end
    end
    if (e_wr != 0) begin
      e_addr = m_addr;
      if (m_addr == DEPTH - 1) m_full = 1;
      else m_addr++;
    end
    if (e_err != 0 && m_cnt < 255) m_cnt++;
    @(posedge Clk);
    #1;
    check_val("wr_en", wr_en, e_wr);
    if (e_wr != 0) begin
      check_val("wr_addr", wr_addr, e_addr);
      check_val("wr_data", wr_data, e_data);
    end
    check_val("err_pulse", err_pulse, e_err);
    if (e_err != 0) check_val("err_code", err_code, e_code);
    check_val("mem_full", mem_full, m_full);
    check_val("err_count", err_count, m_cnt);
  endtask

  task automatic drive(input int op, input int rd, input int rs, input int imm);
    bus.in_valid = 1'b1;
    bus.in_op    = 5'(op);
    bus.in_rd    = 3'(rd);
    bus.in_rs    = 3'(rs);
    bus.in_imm   = 8'(imm);
  endtask

  task automatic send(input int op, input int rd, input int rs, input int imm);
    drive(op, rd, rs, imm);
    step();
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    bus.in_valid = 1'b0; bus.in_op = 5'd0; bus.in_rd = 3'd0; bus.in_rs = 3'd0; bus.in_imm = 8'd0;
    Reset_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    idle(1);

    // add r1,r2 -> 0x006 at address 0
    send(0, 1, 2, 0);
    check_val("t1.wr_data", wr_data, 9'h006);
    idle(1);

    // back-to-back beq/li/mov/jmp from address 0
    send(20, 0, 0, 0);
    send(11, 0, 0, 8'hFD);
    check_val("t2.beq", wr_data, 9'h0FD);
    send(12, 0, 0, 9);
    check_val("t2.li", wr_data, 9'h109);
    send(17, 5, 3, 0);
    check_val("t2.mov", wr_data, 9'h1AB);
    send(18, 0, 0, 40);
    check_val("t2.jmp", wr_data, 9'h1E8);
    idle(1);

    // FILL 3 with the next instruction already waiting
    send(19, 0, 0, 3);
    drive(1, 0, 1, 0);
    for (int i = 0; i < 4; i++) step();
    send(19, 0, 0, 0);
    idle(1);

    // range and reserved-op errors, then confirm the address did not move
    send(0, 5, 0, 0);
    send(8, 0, 0, 20);
    send(25, 0, 0, 0);
    check_val("t4.err_count", err_count, 3);
    send(16, 0, 0, 0);
    idle(1);

    // end of memory: two nops fill 14/15, third overflows, ORG 0 recovers
    send(20, 0, 0, 14);
    send(16, 0, 0, 0);
    send(16, 0, 0, 0);
    send(16, 0, 0, 0);
    check_val("t5.err_code", err_code, 2);
    send(5, 0, 0, 0);
    send(19, 0, 0, 2);
    idle(2);
    send(20, 0, 0, 0);
    idle(1);

    // reset in the middle of a long fill
    send(19, 0, 0, 10);
    idle(4);
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midfill");
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      check_val("rst.wr_en", wr_en, 0);
    end
    Reset_n = 1'b1;
    idle(4);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int op, imm;
      op  = $urandom_range(0, 31);
      imm = (op == 19) ? $urandom_range(0, 4) : $urandom_range(0, 255);
      drive(op, $urandom_range(0, 7), $urandom_range(0, 7), imm);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      step();
    end
    check_val("sat.err_count", err_count, 255);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
